// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: producer drives data/valid, transmitter returns ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data LSB first, odd parity (UART_TX_PARITY_EN), stop; one-entry hold.
// Latency: first start-bit cycle one edge after accept when idle; back-to-back frames with no gap.
// Backpressure: tx_ready = hold register empty, registered, no path from tx_valid.
module uart_tx #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave tx,
    output logic     tx_serial,
    output logic     tx_busy,
    output logic     tx_done
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state;
    logic [7:0] clk_cnt;
    logic [2:0] bit_index;
    logic [7:0] shift;
    logic [7:0] hold;
    logic       hold_full;

    assign tx.tx_ready = ~hold_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_index <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Accept only into an empty hold; the transfer below only fires when it is full,
            // so the two updates of hold_full can never collide.
            if (tx.tx_valid && !hold_full) begin
                hold      <= tx.tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (hold_full) begin
                        shift     <= hold;
                        hold_full <= 1'b0;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= '0;
                        bit_index <= '0;
                        tx_serial <= shift[0];
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        if (bit_index == 3'd7) begin
                            bit_index <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_serial <= ~^shift;
                            state     <= PARITY;
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            tx_serial <= shift[bit_index + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= '0;
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        tx_done <= 1'b1;
                        // A byte already waiting starts its frame on this same edge.
                        if (hold_full) begin
                            shift     <= hold;
                            hold_full <= 1'b0;
                            tx_serial <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
                default: begin
                    clk_cnt   <= '0;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
